// File: rtl/fetch_pkg.sv
// Shared constants, entry type and width helpers for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int          FQ_ADDR_W  = 32;
  localparam int          FQ_INSTR_W = 32;

  typedef struct packed {
    logic [FQ_ADDR_W-1:0]  pc;
    logic [FQ_INSTR_W-1:0] instr;
    logic                  filled;
  } fq_entry_t;

  // Queue pointers carry one extra wrap bit so full and empty differ.
  function automatic int fq_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int fq_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: entries are allocated at issue, filled by responses
// in request order and popped by Decode; clear empties everything at once.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int FQ_DEPTH    = 4,
  localparam int PW         = fq_ptr_w(FQ_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alloc_en,
  input  logic [ADDR_WIDTH-1:0]  alloc_pc,
  input  logic                   fill_en,
  input  logic [INSTR_WIDTH-1:0] fill_data,
  input  logic                   pop_en,
  input  logic                   clear,
  output logic [ADDR_WIDTH-1:0]  head_pc,
  output logic [INSTR_WIDTH-1:0] head_instr,
  output logic                   head_filled,
  output logic [PW-1:0]          alloc_cnt,
  output logic [PW-1:0]          unfilled_cnt
);

  localparam int IW = PW - 1;

  logic [PW-1:0]          head_q, head_d, fill_q, fill_d, tail_q, tail_d;
  logic [IW-1:0]          head_idx, fill_idx, tail_idx;
  logic [FQ_DEPTH-1:0]    filled_vec;
  logic [ADDR_WIDTH-1:0]  pc_mem    [FQ_DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [FQ_DEPTH];

  assign head_idx = head_q[IW-1:0];
  assign fill_idx = fill_q[IW-1:0];
  assign tail_idx = tail_q[IW-1:0];

  always_comb begin
    head_d = head_q;
    fill_d = fill_q;
    tail_d = tail_q;
    if (clear) begin
      head_d = '0;
      fill_d = '0;
      tail_d = '0;
    end else begin
      if (alloc_en) tail_d = tail_q + PW'(1);
      if (fill_en)  fill_d = fill_q + PW'(1);
      if (pop_en)   head_d = head_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      fill_q <= fill_d;
      tail_q <= tail_d;
    end
  end

  // Pop, fill and alloc never target the same slot in one cycle, so the
  // priority below only matters for clear.
  for (genvar gi = 0; gi < FQ_DEPTH; gi++) begin : g_entry
    logic filled_q, filled_d;

    always_comb begin
      filled_d = filled_q;
      if (clear)                                  filled_d = 1'b0;
      else if (pop_en   && head_idx == IW'(gi))   filled_d = 1'b0;
      else if (fill_en  && fill_idx == IW'(gi))   filled_d = 1'b1;
      else if (alloc_en && tail_idx == IW'(gi))   filled_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) filled_q <= 1'b0;
      else        filled_q <= filled_d;
    end

    assign filled_vec[gi] = filled_q;
  end

  always_ff @(posedge clk) begin
    if (alloc_en && !clear) pc_mem[tail_idx]    <= alloc_pc;
    if (fill_en && !clear)  instr_mem[fill_idx] <= fill_data;
  end

  assign head_pc      = pc_mem[head_idx];
  assign head_instr   = instr_mem[head_idx];
  assign head_filled  = filled_vec[head_idx];
  assign alloc_cnt    = tail_q - head_q;
  assign unfilled_cnt = tail_q - fill_q;

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage: issues sequential PCs to instruction memory, tracks responses
// owed by flushed requests, and hands queued instructions to Decode.
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    FQ_DEPTH    = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   PCSrc_E,
  input  logic [ADDR_WIDTH-1:0]  PCTarget_E,
  output logic                   imem_req_valid,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_req_ready,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  input  logic                   D_ready,
  output logic                   D_valid,
  output logic [INSTR_WIDTH-1:0] Ins_D,
  output logic [ADDR_WIDTH-1:0]  PC_D,
  output logic [ADDR_WIDTH-1:0]  PC_4D
);

  localparam int PW = fq_ptr_w(FQ_DEPTH);
  localparam int DW = fq_cnt_w(FQ_DEPTH);
  localparam int SW = ((PW > DW) ? PW : DW) + 1;

  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [DW-1:0]          drop_cnt_q, drop_cnt_d;
  logic [PW-1:0]          alloc_cnt, unfilled_cnt;
  logic [ADDR_WIDTH-1:0]  head_pc;
  logic [INSTR_WIDTH-1:0] head_instr;
  logic                   head_filled;
  logic                   req_fire, fill_en, pop_en, owed_none;

  fetch_queue #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH),
    .FQ_DEPTH    (FQ_DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_en     (req_fire),
    .alloc_pc     (fetch_pc_q),
    .fill_en      (fill_en),
    .fill_data    (imem_rsp_data),
    .pop_en       (pop_en),
    .clear        (PCSrc_E),
    .head_pc      (head_pc),
    .head_instr   (head_instr),
    .head_filled  (head_filled),
    .alloc_cnt    (alloc_cnt),
    .unfilled_cnt (unfilled_cnt)
  );

  assign imem_req_addr = fetch_pc_q;

  always_comb begin
    // Slots still owed a response (live or dropped) bound new issues.
    imem_req_valid = rst_n && !PCSrc_E &&
                     ((SW'(alloc_cnt) + SW'(drop_cnt_q)) < SW'(FQ_DEPTH));
    req_fire  = imem_req_valid && imem_req_ready;
    owed_none = (drop_cnt_q == '0) && (unfilled_cnt == '0);
    fill_en   = imem_rsp_valid && !PCSrc_E && (drop_cnt_q == '0) && (unfilled_cnt != '0);
    D_valid   = head_filled && (alloc_cnt != '0) && !PCSrc_E;
    pop_en    = D_valid && D_ready;
    Ins_D     = D_valid ? head_instr : INSTR_WIDTH'(NOP_INSTR);
    PC_D      = D_valid ? head_pc : '0;
    PC_4D     = D_valid ? head_pc + ADDR_WIDTH'(4) : '0;

    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (PCSrc_E) begin
      fetch_pc_d = PCTarget_E;
      // A response arriving in the flush cycle is one fewer still owed.
      if (imem_rsp_valid && !owed_none)
        drop_cnt_d = drop_cnt_q + DW'(unfilled_cnt) - DW'(1);
      else
        drop_cnt_d = drop_cnt_q + DW'(unfilled_cnt);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
      if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && owed_none));

endmodule
